// File: rtl/spi_poll_pkg.sv
// spi_poll_pkg: shared types and helpers for the SPI temperature poller.
//   state_e     - poller FSM states
//   SCK_IDLE    - serial clock level while no transfer is running
//   ch_width(n) - bits needed to index n channels (at least 1)
package spi_poll_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_WAIT_PERIOD
    } state_e;

    localparam logic SCK_IDLE = 1'b0;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK generator toggling every CLK_DIV cycles while enabled.
//   clk_i   - system clock
//   rstn_i  - synchronous active-low reset
//   en_i    - run; low clears the divider and parks SCK at SCK_IDLE
//   sck_o   - registered serial clock
//   rise_o  - high in the cycle whose closing edge drives SCK high
//   fall_o  - high in the cycle whose closing edge drives SCK low
module spi_sck_gen
    import spi_poll_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          tick;

    always_comb begin
        tick  = en_i && (div_q == DW'(CLK_DIV - 1));
        div_d = (!en_i || tick) ? '0 : div_q + 1'b1;
        sck_d = !en_i ? SCK_IDLE : (tick ? ~sck_q : sck_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            div_q <= '0;
            sck_q <= SCK_IDLE;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = tick & ~sck_q;
    assign fall_o = tick & sck_q;

endmodule

// File: rtl/spi_temp_poller.sv
// spi_temp_poller: round-robin poller for N_CH SPI temperature sensors with alarms.
//   sysclk_i     - system clock (rising edge)
//   rstn_i       - synchronous active-low reset
//   enable_i     - polling runs while high; low stops after the current transfer
//   thresh_hi_i  - signed alarm-set threshold
//   thresh_lo_i  - signed alarm-clear threshold
//   sio_i        - serial data from the selected sensor
//   sck_o        - serial clock, idle low
//   cs_o         - active-low chip-selects, at most one low
//   data_out_o   - last captured word
//   data_ch_o    - channel of data_out_o
//   data_valid_o - one-cycle strobe when data_out_o/data_ch_o update
//   alarm_o      - per-channel over-temperature flags
//   busy_o       - high while any chip-select is low
module spi_temp_poller
    import spi_poll_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYC    = 8,
    parameter int PERIOD_CYC = 1024
) (
    input  logic                      sysclk_i,
    input  logic                      rstn_i,
    input  logic                      enable_i,
    input  logic [DATA_W-1:0]         thresh_hi_i,
    input  logic [DATA_W-1:0]         thresh_lo_i,
    input  logic                      sio_i,
    output logic                      sck_o,
    output logic [N_CH-1:0]           cs_o,
    output logic [DATA_W-1:0]         data_out_o,
    output logic [ch_width(N_CH)-1:0] data_ch_o,
    output logic                      data_valid_o,
    output logic [N_CH-1:0]           alarm_o,
    output logic                      busy_o
);
    localparam int CH_W = ch_width(N_CH);
    localparam int CW   = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
    localparam int BW   = $clog2(DATA_W + 1);
    localparam int PW   = $clog2(PERIOD_CYC);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, dch_q, dch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [PW-1:0]     per_q, per_d;
    logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
    logic [N_CH-1:0]   cs_q, cs_d, alarm_q, alarm_d;
    logic              stop_q, stop_d, valid_q, valid_d;
    logic              sck_en, sck_rise, sck_fall, hi_hit, lo_hit;

    assign sck_en = (state_q == S_SETUP) || (state_q == S_SHIFT);
    assign hi_hit = $signed(sh_q) > $signed(thresh_hi_i);
    assign lo_hit = $signed(sh_q) < $signed(thresh_lo_i);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk_i  (sysclk_i),
        .rstn_i (rstn_i),
        .en_i   (sck_en),
        .sck_o  (sck_o),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        per_d   = (per_q == PW'(PERIOD_CYC - 1)) ? '0 : per_q + 1'b1;
        sh_d    = sck_rise ? {sh_q[DATA_W-2:0], sio_i} : sh_q;
        // a stop request anywhere in a transfer is remembered until it finishes
        stop_d  = stop_q | ~enable_i;
        data_d  = data_q;
        dch_d   = dch_q;
        valid_d = 1'b0;
        alarm_d = alarm_q;
        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                per_d  = '0;
                if (enable_i) begin
                    state_d = S_SETUP;
                    ch_d    = '0;
                end
            end
            S_SETUP: begin
                bit_d = '0;
                if (sck_rise) state_d = S_SHIFT;
            end
            S_SHIFT: if (sck_fall) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(DATA_W - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: if (cnt_q == CW'(CLK_DIV - 1)) begin
                valid_d       = 1'b1;
                data_d        = sh_q;
                dch_d         = ch_q;
                // set wins over clear when the thresholds overlap
                alarm_d[ch_q] = hi_hit | (~lo_hit & alarm_q[ch_q]);
                state_d       = stop_d ? S_IDLE : S_GAP;
                cnt_d         = '0;
            end
            S_GAP: begin
                if (!enable_i) state_d = S_IDLE;
                else if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = (ch_q < CH_W'(N_CH - 1)) ? S_SETUP : S_WAIT_PERIOD;
                    ch_d    = (ch_q < CH_W'(N_CH - 1)) ? ch_q + 1'b1 : '0;
                end
            end
            S_WAIT_PERIOD: begin
                if (!enable_i) state_d = S_IDLE;
                else if (per_q == PW'(PERIOD_CYC - 1)) state_d = S_SETUP;
            end
            default: state_d = S_IDLE;
        endcase
        cs_d = (state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD)
             ? ~(N_CH'(1) << ch_d) : '1;
    end

    always_ff @(posedge sysclk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            dch_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            cs_q    <= '1;
            alarm_q <= '0;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dch_q   <= dch_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            alarm_q <= alarm_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
        end
    end

    assign cs_o         = cs_q;
    assign data_out_o   = data_q;
    assign data_ch_o    = dch_q;
    assign data_valid_o = valid_q;
    assign alarm_o      = alarm_q;
    assign busy_o       = ~&cs_q;

endmodule

// File: tb/tb_spi_temp_poller.sv
// tb_spi_temp_poller: directed self-checking bench for spi_temp_poller (4 sensors).
module tb_spi_temp_poller;
    import spi_poll_pkg::*;

    logic        clk, rstn, enable, sio;
    logic [15:0] thresh_hi, thresh_lo;
    logic        sck, data_valid, busy;
    logic [3:0]  cs, alarm;
    logic [15:0] data_out;
    logic [1:0]  data_ch;

    int errors = 0;
    int checks = 0;

    spi_temp_poller dut (
        .sysclk_i     (clk),
        .rstn_i       (rstn),
        .enable_i     (enable),
        .thresh_hi_i  (thresh_hi),
        .thresh_lo_i  (thresh_lo),
        .sio_i        (sio),
        .sck_o        (sck),
        .cs_o         (cs),
        .data_out_o   (data_out),
        .data_ch_o    (data_ch),
        .data_valid_o (data_valid),
        .alarm_o      (alarm),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sensor model: each selected sensor shifts its word out MSB first, next bit after each SCK rise
    logic [15:0] word [4];
    logic [15:0] cur;
    logic [3:0]  nbit;
    logic        sck_t;
    always_comb begin
        cur = '0;
        for (int i = 0; i < 4; i++) if (!cs[i]) cur = word[i];
    end
    assign sio = busy & cur[~nbit];
    always @(posedge clk) begin
        sck_t <= sck;
        nbit  <= !busy ? 4'd0 : (sck && !sck_t) ? nbit + 1'b1 : nbit;
    end

    // timing monitor: CS-low length, SCK rises per transfer, SCK rise spacing, round starts
    int   cyc = 0, cur_len = 0, low_len = 0, rises = 0, last_rise = 0, rise_gap = 0;
    logic busy_p = 1'b0, sck_p = 1'b0;
    int   round_start [$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy) cur_len <= cur_len + 1;
        if (busy && !busy_p) begin
            cur_len <= 1;
            rises   <= 0;
            if (cs == 4'b1110) round_start.push_back(cyc);
        end
        if (!busy && busy_p) low_len <= cur_len;
        if (sck && !sck_p) begin
            rises     <= rises + 1;
            rise_gap  <= cyc - last_rise;
            last_rise <= cyc;
        end
        busy_p <= busy;
        sck_p  <= sck;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wait for a data_valid strobe (on channel ch, or any channel when ch < 0)
    task automatic wait_ch(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(data_valid && (ch < 0 || int'(data_ch) == ch)) && n < 4000);
        if (n >= 4000) chk("valid_timeout", 0, 1);
    endtask

    // per ch0 poll: thresholds, ch0 word, expected alarm[0] after the strobe
    logic [15:0] hi_t [9] = '{16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00,
                              16'hFF00, 16'hFF00, 16'h0000};
    logic [15:0] lo_t [9] = '{16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00,
                              16'hFE00, 16'hFE00, 16'h0100};
    logic [15:0] w_t  [9] = '{16'h0B00, 16'h0C80, 16'h0B00, 16'h0A00, 16'h0900, 16'h0C00,
                              16'hFF80, 16'h8000, 16'h0080};
    logic [8:0]  a_t      = 9'b101001110;

    initial begin
        int n;
        int bad;
        rstn      = 1'b0;
        enable    = 1'b0;
        thresh_hi = 16'h7FFF;
        thresh_lo = 16'h8000;
        for (int i = 0; i < 4; i++) word[i] = 16'h0100 * 16'(i + 1);
        repeat (3) @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_cs", cs, 4'hF);
        chk("rst_data", data_out, 0);
        chk("rst_ch", data_ch, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_cs", cs, 4'hF);
        enable = 1'b1;

        for (int c = 0; c < 4; c++) begin
            wait_ch(-1);
            chk("rr_ch", data_ch, c);
            chk("rr_data", data_out, 16'h0100 * (c + 1));
            chk("rr_cs_at_valid", cs, 4'hF);
            @(negedge clk);
            chk("rr_valid_1cyc", data_valid, 0);
            chk("rr_cs_low_len", low_len, 132);
            chk("rr_sck_rises", rises, 16);
            chk("rr_sck_period", rise_gap, 8);
        end
        wait_ch(-1);
        chk("r2_ch", data_ch, 0);
        chk("r2_data", data_out, 16'h0100);
        if (round_start.size() < 2) chk("round_count", round_start.size(), 2);
        else chk("round_period", round_start[1] - round_start[0], 1024);

        for (int r = 0; r < 9; r++) begin
            thresh_hi = hi_t[r];
            thresh_lo = lo_t[r];
            word[0]   = w_t[r];
            wait_ch(0);
            chk("alarm_data", data_out, w_t[r]);
            chk("alarm0", alarm[0], a_t[r]);
        end

        word[1] = 16'h1234;
        n = 0;
        while (!(cs == 4'b1101 && rises == 5) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("dis_wait_timeout", 0, 1);
        enable = 1'b0;
        wait_ch(1);
        chk("dis_data", data_out, 16'h1234);
        chk("dis_cs", cs, 4'hF);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy || sck || data_valid) bad++;
        end
        chk("dis_quiet", bad, 0);
        chk("dis_state", dut.state_q, S_IDLE);

        enable = 1'b1;
        n = 0;
        while (!(cs == 4'b1011 && rises == 3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("rst_wait_timeout", 0, 1);
        chk("pre_rst_alarm", alarm, 4'hF);
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_cs", cs, 4'hF);
        chk("mrst_sck", sck, 0);
        chk("mrst_alarm", alarm, 0);
        chk("mrst_valid", data_valid, 0);
        chk("mrst_data", data_out, 0);
        rstn = 1'b1;
        wait_ch(-1);
        chk("restart_ch", data_ch, 0);
        chk("restart_data", data_out, 16'h0080);
        chk("restart_alarm", alarm, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_temp_poller.md
Name: spi_temp_poller

Overview:
Parametrised successor to the single-sensor SPI temperature reader. Autonomously polls N_CH SPI temperature sensors sharing SCK/SIO, each with its own active-low chip-select, in round-robin order once per sample period. Presents each captured word with a channel tag and a one-cycle valid strobe. Maintains a per-channel over-temperature alarm with hysteresis. Sits between the sensor pins and the display/host logic.

Parameters:
N_CH, 4, number of sensors / chip-selects (1..8)
DATA_W, 16, bits shifted per transaction, MSB first (2..32)
CLK_DIV, 4, SYSCLK cycles per SCK half-period (>=2)
GAP_CYC, 8, idle SYSCLK cycles between consecutive channel transactions (>=1)
PERIOD_CYC, 1024, SYSCLK cycles from one round start to the next; must be >= N_CH*(2*CLK_DIV*DATA_W + CLK_DIV + 1 + GAP_CYC)

Ports:
SYSCLK  in  1  system clock, all logic on rising edge
RSTN  in  1  synchronous active-low reset
enable  in  1  1 = polling runs; 0 = stop after current transaction
thresh_hi  in  DATA_W  signed alarm-set threshold
thresh_lo  in  DATA_W  signed alarm-clear threshold
SIO  in  1  serial data from the selected sensor
SCK  out  1  serial clock, idle low
CS  out  N_CH  chip-selects, active low, at most one low
data_out  out  DATA_W  last captured word
data_ch  out  $clog2(N_CH) (min 1)  channel of data_out
data_valid  out  1  one-cycle strobe: data_out/data_ch updated
alarm  out  N_CH  per-channel over-temperature flags
busy  out  1  high while any CS is low

Behaviour:
- Reset (RSTN=0 at a SYSCLK edge): SCK=0, CS=all 1, data_out=0, data_ch=0, data_valid=0, alarm=0, busy=0, FSM=IDLE, channel pointer=0, period counter=0. Reset mid-transaction aborts it at that edge; no data_valid.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP, WAIT_PERIOD.
- IDLE: when enable=1, start round at ch 0, period counter restarts at 0 → SETUP.
- SETUP: CS[ch] low (cycle T0 = entry edge); after CLK_DIV cycles → SHIFT.
- SHIFT: SCK toggles every CLK_DIV cycles, starting with a rise at T0+CLK_DIV. Rising edge k (k=0..DATA_W-1) at T0+CLK_DIV*(2k+1); SIO sampled on the same SYSCLK edge that drives SCK high, shifted in MSB first. After the DATA_W-th falling edge (T0+2*CLK_DIV*DATA_W) → HOLD with SCK=0.
- HOLD: CLK_DIV cycles later CS[ch] returns high; on that same edge data_out=shift reg, data_ch=ch, data_valid=1 (exactly one cycle), alarm[ch] updated. Default transaction: CS low for 132 cycles.
- Alarm (signed compare of the captured word): word > thresh_hi → alarm[ch]=1; word < thresh_lo → alarm[ch]=0; otherwise hold. Equality holds. thresh_lo > thresh_hi: set takes priority.
- GAP: GAP_CYC cycles with all CS high. If ch < N_CH-1: ch+1 → SETUP. Else ch=0 → WAIT_PERIOD.
- WAIT_PERIOD: wait until period counter == PERIOD_CYC-1, then counter wraps to 0 and → SETUP (new round) if enable=1, else → IDLE.
- enable=0 during SETUP/SHIFT/HOLD: transaction completes normally with data_valid; then → IDLE (GAP skipped). enable=0 in GAP/WAIT_PERIOD: → IDLE next edge. Re-enable always restarts at ch 0.
- busy = OR of inverted CS; SCK never toggles while all CS are high.
- Period counter free-runs from round start and wraps; counter width = $clog2(PERIOD_CYC).

Decomposition:
- Package spi_poll_pkg: FSM state enum, SCK idle level constant (0), helper function for channel-index width (min 1).
- One sub-module: spi_sck_gen. A CLK_DIV half-period counter producing registered SCK and single-cycle rise/fall strobes, enabled by the FSM and cleared on reset/abort.

Test Plan:
- Single read: N_CH=1, sensor model returns 16'h0C87 → CS low 132 cycles, 16 SCK pulses of period 8, data_valid once with data_out=16'h0C87, data_ch=0.
- Round-robin: N_CH=4, models return 16'h0100/16'h0200/16'h0300/16'h0400 → four data_valid strobes in channel order 0..3 with matching words; next round starts exactly PERIOD_CYC cycles after the first.
- Alarm hysteresis: thresh_hi=16'h0C00, thresh_lo=16'h0A00; ch0 words 0x0B00, 0x0C80, 0x0B00, 0x0900 → alarm[0] = 0,1,1,0 after each strobe.
- Negative compare: thresh_hi=16'hFF00; word 16'hFF80 → alarm set; word 16'h8000 → alarm clears if thresh_lo=16'hFE00.
- Disable mid-shift: drop enable at SCK rise 5 of ch1 → ch1 completes with data_valid; CS all high; FSM in IDLE; no further SCK edges.
- Reset mid-shift: RSTN=0 for 1 cycle during ch2 → next edge CS=all 1, SCK=0, alarm=0, no data_valid; polling restarts at ch0 once RSTN=1.
